// File: rtl/serial_buf_pkg.sv
// Shared definitions for the serial link receive side: field widths, frame length, FSM states.
package serial_buf_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;
    localparam int FRAME_BITS = 1 + ADDR_W_DEF + DATA_W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        STOP,
        WAIT
    } rx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_rx_shreg.sv
// MSB-first shift-in register with synchronous clear and shift enable.
module serial_rx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         shift_en,
    input  logic         din,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/serial_in_buffer.sv
// Receive end of the two-wire serial link: start + address + data + stop, InC active-low frame valid.
// Optional ADDR_MATCH_EN: good frames not addressed to OWN_ADDR are dropped silently.
module serial_in_buffer
    import serial_buf_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                DATA_W   = DATA_W_DEF,
    parameter logic [ADDR_W-1:0] OWN_ADDR = '0
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              InD,
    input  logic              InC,
    output logic [ADDR_W-1:0] A_out,
    output logic [DATA_W-1:0] D_out,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(max_int(ADDR_W, DATA_W)) + 1;
    localparam logic [CNT_W-1:0]  ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);
`ifdef ADDR_MATCH_EN
    localparam bit MATCH_EN = 1'b1;
`else
    localparam bit MATCH_EN = 1'b0;
`endif

    rx_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic              c_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              frame_start;
    logic              addr_ok;

    // A start is a falling edge of InC seen from IDLE
    assign frame_start = (state == IDLE) && c_q && !InC;
    assign addr_ok     = !MATCH_EN || (addr_q == OWN_ADDR);

    serial_rx_shreg #(.W(ADDR_W)) u_addr_sr (
        .clk      (clk_in),
        .clr      (reset || frame_start),
        .shift_en ((state == ADDR) && !InC),
        .din      (InD),
        .q        (addr_q)
    );

    serial_rx_shreg #(.W(DATA_W)) u_data_sr (
        .clk      (clk_in),
        .clr      (reset || frame_start),
        .shift_en ((state == DATA) && !InC),
        .din      (InD),
        .q        (data_q)
    );

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            c_q      <= 1'b1;
            A_out    <= '0;
            D_out    <= '0;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            c_q      <= InC;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (frame_start) begin
                        if (!InD) begin
                            state <= ADDR;
                            busy  <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                            state  <= WAIT;
                        end
                    end
                end
                ADDR, DATA: begin
                    if (InC) begin
                        rx_err <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else if (state == ADDR && cnt == ADDR_LAST) begin
                        cnt   <= '0;
                        state <= DATA;
                    end else if (state == DATA && cnt == DATA_LAST) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    if (InC) begin
                        rx_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        state <= WAIT;
                        if (InD) begin
                            rx_err <= 1'b1;
                        end else if (addr_ok) begin
                            A_out    <= addr_q;
                            D_out    <= data_q;
                            rx_valid <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= '0;
                    if (InC) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_in_buffer.sv
// Directed bench for serial_in_buffer; frame-level scenarios with hand-computed expectations.
module tb_serial_in_buffer;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       InD;
    logic       InC;
    logic [6:0] A_out;
    logic [7:0] D_out;
    logic       rx_valid;
    logic       rx_err;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    serial_in_buffer #(
        .ADDR_W   (7),
        .DATA_W   (8),
        .OWN_ADDR (7'h41)
    ) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .InD      (InD),
        .InC      (InC),
        .A_out    (A_out),
        .D_out    (D_out),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .busy     (busy)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic step(input logic c, input logic d);
        InC = c;
        InD = d;
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_frame(input logic [6:0] a, input logic [7:0] d, input logic stop);
        logic [16:0] f;
        f = {1'b0, a, d, stop};
        for (int i = 16; i >= 0; i--) step(1'b0, f[i]);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(1'b1, 1'bx);
        step(1'b1, 1'bx);
        checks++; if (A_out !== 7'h00) begin errors++; $display("FAIL reset_A got %h exp 00", A_out); end
        checks++; if (D_out !== 8'h00) begin errors++; $display("FAIL reset_D got %h exp 00", D_out); end
        checks++; if ({rx_valid, rx_err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {rx_valid, rx_err, busy}); end
        reset = 1'b0;
        step(1'b1, 1'bx);
    endtask

    task automatic test_all_ones;
        step(1'b0, 1'b0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ones_busy got %b exp 1", busy); end
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ones_early_valid got %b exp 0", rx_valid); end
        step(1'b0, 1'b0);
        checks++; if (A_out !== 7'h7F) begin errors++; $display("FAIL ones_A got %h exp 7f", A_out); end
        checks++; if (D_out !== 8'hFF) begin errors++; $display("FAIL ones_D got %h exp ff", D_out); end
        checks++; if ({rx_valid, rx_err, busy} !== 3'b100) begin errors++; $display("FAIL ones_flags got %b exp 100", {rx_valid, rx_err, busy}); end
        step(1'b1, 1'bx);
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ones_pulse got %b exp 0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        int c1;
        send_frame(7'b1000001, 8'b10011111, 1'b0);
        c1 = cyc;
        checks++; if ({rx_valid, A_out, D_out} !== {1'b1, 7'h41, 8'h9F}) begin errors++; $display("FAIL b2b_first got %b %h %h exp 1 41 9f", rx_valid, A_out, D_out); end
        step(1'b1, 1'bx);
        send_frame(7'h2A, 8'h55, 1'b0);
        checks++; if ({rx_valid, A_out, D_out} !== {1'b1, 7'h2A, 8'h55}) begin errors++; $display("FAIL b2b_second got %b %h %h exp 1 2a 55", rx_valid, A_out, D_out); end
        checks++; if (cyc - c1 !== 18) begin errors++; $display("FAIL b2b_spacing got %0d exp 18", cyc - c1); end
        step(1'b1, 1'bx);
    endtask

    task automatic test_bad_stop;
        send_frame(7'h11, 8'h22, 1'b1);
        checks++; if ({rx_valid, rx_err} !== 2'b01) begin errors++; $display("FAIL badstop_flags got %b exp 01", {rx_valid, rx_err}); end
        checks++; if ({A_out, D_out} !== {7'h2A, 8'h55}) begin errors++; $display("FAIL badstop_hold got %h %h exp 2a 55", A_out, D_out); end
        step(1'b1, 1'bx);
        checks++; if (rx_err !== 1'b0) begin errors++; $display("FAIL badstop_pulse got %b exp 0", rx_err); end
    endtask

    task automatic test_bad_start;
        step(1'b0, 1'b1);
        checks++; if ({rx_err, busy} !== 2'b10) begin errors++; $display("FAIL badstart got %b exp 10", {rx_err, busy}); end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        checks++; if ({rx_valid, rx_err, busy} !== 3'b000) begin errors++; $display("FAIL badstart_absorb got %b exp 000", {rx_valid, rx_err, busy}); end
        step(1'b1, 1'bx);
    endtask

    task automatic test_abort;
        step(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'bx);
        checks++; if ({rx_valid, rx_err, busy} !== 3'b010) begin errors++; $display("FAIL abort_flags got %b exp 010", {rx_valid, rx_err, busy}); end
        send_frame(7'h33, 8'hC3, 1'b0);
        checks++; if ({rx_valid, A_out, D_out} !== {1'b1, 7'h33, 8'hC3}) begin errors++; $display("FAIL abort_next got %b %h %h exp 1 33 c3", rx_valid, A_out, D_out); end
        step(1'b1, 1'bx);
    endtask

    task automatic test_long_frame;
        send_frame(7'h01, 8'h80, 1'b0);
        checks++; if ({rx_valid, A_out, D_out} !== {1'b1, 7'h01, 8'h80}) begin errors++; $display("FAIL long_data got %b %h %h exp 1 01 80", rx_valid, A_out, D_out); end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
        checks++; if ({rx_valid, rx_err, busy} !== 3'b000) begin errors++; $display("FAIL long_absorb got %b exp 000", {rx_valid, rx_err, busy}); end
        step(1'b1, 1'bx);
    endtask

    task automatic test_reset_mid;
        logic [16:0] f;
        f = {1'b0, 7'h7E, 8'hE7, 1'b0};
        for (int i = 16; i > 7; i--) step(1'b0, f[i]);
        reset = 1'b1;
        step(1'b0, f[7]);
        reset = 1'b0;
        checks++; if ({A_out, D_out} !== 15'h0) begin errors++; $display("FAIL rstmid_data got %h %h exp 00 00", A_out, D_out); end
        checks++; if ({rx_valid, rx_err, busy} !== 3'b000) begin errors++; $display("FAIL rstmid_flags got %b exp 000", {rx_valid, rx_err, busy}); end
        step(1'b1, 1'bx);
        send_frame(7'h5A, 8'hA5, 1'b0);
        checks++; if ({rx_valid, A_out, D_out} !== {1'b1, 7'h5A, 8'hA5}) begin errors++; $display("FAIL rstmid_next got %b %h %h exp 1 5a a5", rx_valid, A_out, D_out); end
        step(1'b1, 1'bx);
    endtask

    task automatic test_addr_match;
        send_frame(7'h41, 8'h3C, 1'b0);
        checks++; if ({rx_valid, rx_err, A_out, D_out} !== {2'b10, 7'h41, 8'h3C}) begin errors++; $display("FAIL match_hit got %b %b %h %h exp 1 0 41 3c", rx_valid, rx_err, A_out, D_out); end
        step(1'b1, 1'bx);
        send_frame(7'h40, 8'hC3, 1'b0);
        checks++; if ({rx_valid, rx_err, A_out, D_out} !== {2'b00, 7'h41, 8'h3C}) begin errors++; $display("FAIL match_miss got %b %b %h %h exp 0 0 41 3c", rx_valid, rx_err, A_out, D_out); end
        step(1'b1, 1'bx);
    endtask

    initial begin
        reset = 1'b1;
        InC   = 1'b1;
        InD   = 1'b0;
        test_reset();
`ifdef ADDR_MATCH_EN
        test_addr_match();
`else
        test_all_ones();
        test_back_to_back();
        test_bad_stop();
        test_bad_start();
        test_abort();
        test_long_frame();
        test_reset_mid();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
